// File: rtl/gravsim_pair_scheduler.sv
// Timestep sequencer for the N-body core: clears accumulators, streams every i<j body pair
// to the force pipeline under credit flow control, then triggers integration and signals done.
module gravsim_pair_scheduler #(
    parameter int MAX_BODIES      = 10,
    parameter int IDX_W           = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] num_bodies,
    output logic             acc_clr,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic [IDX_W-1:0] pair_i,
    output logic [IDX_W-1:0] pair_j,
    output logic             pair_last,
    input  logic             res_valid,
    output logic             integ_start,
    input  logic             integ_done,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IDX_W-1:0] MAX_N   = IDX_W'(MAX_BODIES);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_INTEG,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0] n_lat;
    logic [IDX_W-1:0] n_clamped;
    logic [IDX_W-1:0] idx_i;
    logic [IDX_W-1:0] idx_j;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic             integ_pulse;
    logic             err_q;
    logic             xfer;
    logic             res_ok;
    logic             last_pair;

    assign n_clamped = (num_bodies > MAX_N) ? MAX_N : num_bodies;
    assign xfer      = pair_valid && pair_ready;
    assign res_ok    = res_valid && (outstanding != '0);
    assign last_pair = (idx_i == n_lat - IDX_W'(2)) && (idx_j == n_lat - IDX_W'(1));

    assign pair_i      = idx_i;
    assign pair_j      = idx_j;
    assign integ_start = integ_pulse;
    assign err         = err_q;

    // A transfer and a returning result in the same cycle cancel; a result with nothing
    // in flight is an error and never underflows the count.
    always_comb begin
        outstanding_next = outstanding;
        if (xfer && !res_ok) begin
            outstanding_next = outstanding + CNT_W'(1);
        end else if (!xfer && res_ok) begin
            outstanding_next = outstanding - CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        acc_clr    = 1'b0;
        pair_valid = 1'b0;
        pair_last  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (n_clamped == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                acc_clr    = 1'b1;
                state_next = (n_lat == IDX_W'(1)) ? S_INTEG : S_ISSUE;
            end
            S_ISSUE: begin
                pair_valid = (outstanding < MAX_CNT);
                pair_last  = pair_valid && last_pair;
                if (pair_valid && pair_ready && last_pair) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Looking at the next count lets a result arriving on the entry cycle finish the drain.
                if (outstanding_next == '0) begin
                    state_next = S_INTEG;
                end
            end
            S_INTEG: begin
                if (integ_done) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lat       <= '0;
            idx_i       <= '0;
            idx_j       <= '0;
            outstanding <= '0;
            integ_pulse <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            integ_pulse <= (state_next == S_INTEG) && (state != S_INTEG);

            if (state == S_IDLE && start) begin
                n_lat <= n_clamped;
            end

            if (res_valid && outstanding == '0) begin
                err_q <= 1'b1;
            end else if (state == S_IDLE && start) begin
                err_q <= 1'b0;
            end

            // Row-major walk over the upper triangle: wrap to (i+1, i+2) at the end of a row.
            if (state == S_CLEAR) begin
                idx_i <= '0;
                idx_j <= IDX_W'(1);
            end else if (xfer) begin
                if (idx_j == n_lat - IDX_W'(1)) begin
                    idx_i <= idx_i + IDX_W'(1);
                    idx_j <= idx_i + IDX_W'(2);
                end else begin
                    idx_j <= idx_j + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gravsim_pair_scheduler.sv
// Scoreboard bench for gravsim_pair_scheduler: expected pairs are queued from a nested-loop
// model and a free-running monitor checks every transfer, credit limit and control pulse.
module tb_gravsim_pair_scheduler;

    localparam int MAX_OUT = 8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] num_bodies;
    logic       acc_clr;
    logic       pair_valid;
    logic       pair_ready;
    logic [3:0] pair_i;
    logic [3:0] pair_j;
    logic       pair_last;
    logic       res_valid;
    logic       integ_start;
    logic       integ_done;
    logic       busy;
    logic       done;
    logic       err;

    gravsim_pair_scheduler #(
        .MAX_BODIES(10),
        .IDX_W(4),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .num_bodies(num_bodies),
        .acc_clr(acc_clr),
        .pair_valid(pair_valid),
        .pair_ready(pair_ready),
        .pair_i(pair_i),
        .pair_j(pair_j),
        .pair_last(pair_last),
        .res_valid(res_valid),
        .integ_start(integ_start),
        .integ_done(integ_done),
        .busy(busy),
        .done(done),
        .err(err)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    logic [8:0] exp_q[$];
    int         res_q[$];

    int model_out = 0;
    int transfers = 0;
    int valid_cnt = 0;
    int acc_cnt = 0;
    int acc_cyc = -1;
    int integ_cnt = 0;
    int integ_cyc = -1;
    int integ_due = -1;
    int done_cnt = 0;
    int done_cyc = -1;
    int first_valid = -1;
    int last_xfer = -1;
    int last_res_cyc = -1;

    int ready_mode = 0;
    int res_lat = 0;
    bit res_enable = 1'b1;
    int release_cnt = 0;
    bit spurious_req = 1'b0;
    bit prev_stall = 1'b0;
    logic [8:0] prev_fields = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Environment: force-pipeline returns, integration completion and ready pattern.
    initial begin
        pair_ready = 1'b0;
        res_valid  = 1'b0;
        integ_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pair_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            res_valid  = 1'b0;
            if (spurious_req) begin
                res_valid    = 1'b1;
                spurious_req = 1'b0;
            end else if (res_q.size() > 0 && res_q[0] <= cyc && (res_enable || release_cnt > 0)) begin
                res_valid = 1'b1;
                void'(res_q.pop_front());
                if (!res_enable) release_cnt--;
            end
            integ_done = (cyc == integ_due);
        end
    end

    // Monitor: pops the scoreboard on each transfer and tracks credits and control pulses.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_stable", {pair_valid, pair_last, pair_i, pair_j}, {1'b1, prev_fields});
            end
            if (pair_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
                checkOutput("credit_limit", 32'(model_out < MAX_OUT), 1);
                checkOutput("pair_order_ij", 32'(pair_i < pair_j), 1);
            end
            if (res_valid && model_out > 0) begin
                model_out--;
                last_res_cyc = cyc;
            end
            if (pair_valid && pair_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_pair", {pair_last, pair_i, pair_j}, 32'h1ff);
                end else begin
                    checkOutput("pair", {pair_last, pair_i, pair_j}, exp_q.pop_front());
                end
                transfers++;
                model_out++;
                last_xfer = cyc;
                res_q.push_back(cyc + ((res_lat > 0) ? res_lat : $urandom_range(1, 6)));
            end
            prev_stall  = pair_valid && !pair_ready;
            prev_fields = {pair_last, pair_i, pair_j};
            if (acc_clr) begin
                acc_cnt++;
                acc_cyc = cyc;
            end
            if (integ_start) begin
                integ_cnt++;
                integ_cyc = cyc;
                integ_due = cyc + $urandom_range(1, 4);
                checkOutput("integ_after_drain", model_out, 0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic prep_step(input int n, input int rmode, input int lat);
        int ne;
        ne = (n > 10) ? 10 : n;
        ready_mode = rmode;
        res_lat = lat;
        exp_q.delete();
        for (int a = 0; a < ne; a++) begin
            for (int b = a + 1; b < ne; b++) begin
                logic [3:0] ai;
                logic [3:0] bi;
                ai = 4'(a);
                bi = 4'(b);
                exp_q.push_back({1'((a == ne - 2) && (b == ne - 1)), ai, bi});
            end
        end
        transfers = 0;
        valid_cnt = 0;
        acc_cnt = 0;
        integ_cnt = 0;
        done_cnt = 0;
        first_valid = -1;
        last_xfer = -1;
        last_res_cyc = -1;
    endtask

    task automatic applyStimulus(input int n, output int s);
        @(posedge clk);
        #1;
        num_bodies = 4'(n);
        start = 1'b1;
        s = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        num_bodies = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (done_cnt == 0 && g < 3000) begin
            tick();
            g++;
        end
        checkOutput("done_seen", 32'(done_cnt > 0), 1);
        repeat (3) tick();
    endtask

    task automatic check_step(input int n, input int s, input int rmode);
        int ne;
        int np;
        ne = (n > 10) ? 10 : n;
        np = ne * (ne - 1) / 2;
        checkOutput("done_once", done_cnt, 1);
        checkOutput("idle_after", {busy, err, pair_valid}, 0);
        checkOutput("transfers", transfers, np);
        checkOutput("leftover_pairs", exp_q.size(), 0);
        checkOutput("acc_clr_count", acc_cnt, (ne >= 1) ? 1 : 0);
        checkOutput("integ_count", integ_cnt, (ne >= 1) ? 1 : 0);
        checkOutput("in_flight", model_out, 0);
        if (ne >= 1) begin
            checkOutput("acc_clr_latency", acc_cyc - s, 1);
            checkOutput("done_after_integ", done_cyc, integ_due + 1);
        end
        if (ne == 1) checkOutput("integ_latency_n1", integ_cyc - s, 2);
        if (ne <= 1) checkOutput("no_pairs", valid_cnt, 0);
        if (ne == 0) checkOutput("n0_done_latency", 32'((done_cyc == s + 1) || (done_cyc == s + 2)), 1);
        if (np > 0) begin
            checkOutput("first_valid_latency", first_valid - s, 2);
            checkOutput("integ_after_last_res", integ_cyc, last_res_cyc + 1);
            if (rmode == 0 && np <= MAX_OUT) checkOutput("back_to_back", last_xfer - s, np + 1);
        end
    endtask

    task automatic run_step(input int n, input int rmode, input int lat);
        int s;
        prep_step(n, rmode, lat);
        applyStimulus(n, s);
        wait_done();
        check_step(n, s, rmode);
    endtask

    initial begin
        int s;
        int g;
        rst_n = 1'b0;
        start = 1'b0;
        num_bodies = '0;
        #23;
        checkOutput("reset_outputs", {acc_clr, pair_valid, pair_i, pair_j, pair_last, integ_start, busy, done, err}, 0);
        @(negedge clk);
        #3;
        rst_n = 1'b1;

        run_step(3, 0, 4);
        run_step(1, 0, 0);
        run_step(0, 0, 0);
        run_step(10, 0, 0);
        run_step(4, 1, 0);
        run_step(13, 1, 0);

        // Credit exhaustion with results withheld, plus a start pulse that must be ignored.
        prep_step(10, 0, 1);
        res_enable = 1'b0;
        applyStimulus(10, s);
        g = 0;
        while (transfers < 8 && g < 50) begin
            tick();
            g++;
        end
        repeat (4) tick();
        checkOutput("credit_stall_valid", pair_valid, 0);
        checkOutput("credit_stall_count", transfers, 8);
        @(posedge clk);
        #1;
        num_bodies = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        release_cnt = 1;
        repeat (8) tick();
        checkOutput("one_credit_one_pair", transfers, 9);
        checkOutput("restall_valid", pair_valid, 0);
        res_enable = 1'b1;
        wait_done();
        check_step(10, s, 0);

        // Asynchronous reset in the middle of pair issue.
        prep_step(10, 0, 3);
        applyStimulus(10, s);
        g = 0;
        while (transfers < 5 && g < 50) begin
            tick();
            g++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset_outputs", {acc_clr, pair_valid, pair_i, pair_j, pair_last, integ_start, busy, done, err}, 0);
        res_q.delete();
        exp_q.delete();
        model_out = 0;
        integ_due = -1;
        repeat (2) tick();
        rst_n = 1'b1;
        run_step(3, 0, 2);

        // A result with nothing in flight sets err, which persists until the next start.
        spurious_req = 1'b1;
        repeat (4) tick();
        checkOutput("err_set", err, 1);
        repeat (3) tick();
        checkOutput("err_sticky", err, 1);
        run_step(2, 1, 0);

        for (int k = 0; k < 6; k++) begin
            run_step($urandom_range(0, 15), $urandom_range(0, 1), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
